// File: rtl/mult_slice_pipe_cfg_pkg.sv
// Shared definitions for the configurable multiplier slice.
// Covers the config-chain bit layout, the decoded mode word and small decode helpers.
package mult_slice_pkg;

    localparam int CFG_W      = 6;
    localparam int CFG_SIGN_A = 0;
    localparam int CFG_SIGN_B = 1;
    localparam int CFG_FRAC   = 2;
    localparam int CFG_LAT_LO = 3;
    localparam int CFG_LAT_HI = 4;
    localparam int CFG_ACC    = 5;

    typedef struct packed {
        logic       sign_a;
        logic       sign_b;
        logic       frac;
        logic [1:0] lat;
        logic       acc_en;
    } mode_t;

    function automatic mode_t decode_mode(input logic [CFG_W-1:0] cfg);
        mode_t m;
        m.sign_a = cfg[CFG_SIGN_A];
        m.sign_b = cfg[CFG_SIGN_B];
        m.frac   = cfg[CFG_FRAC];
        m.lat    = cfg[CFG_LAT_HI:CFG_LAT_LO];
        m.acc_en = cfg[CFG_ACC];
        return m;
    endfunction

    // Encoding 3 is not a distinct depth; it runs as the deepest pipeline.
    function automatic logic [1:0] clamp_lat(input logic [1:0] lat);
        return (lat == 2'd3) ? 2'd2 : lat;
    endfunction

endpackage

// File: rtl/mult_slice_pipe_cfg_if.sv
// Operand/result bundle of the multiplier slice.
// The master drives operands, the slice (slave) returns results.
interface mult_slice_pipe_cfg_if #(
    parameter int A_W = 18,
    parameter int B_W = 18
);
    logic               in_valid;
    logic [A_W-1:0]     mult_A;
    logic [B_W-1:0]     mult_B;
    logic               acc_clr;
    logic               out_valid;
    logic [A_W+B_W-1:0] mult_Y;

    modport master (
        output in_valid, mult_A, mult_B, acc_clr,
        input  out_valid, mult_Y
    );

    modport slave (
        input  in_valid, mult_A, mult_B, acc_clr,
        output out_valid, mult_Y
    );
endinterface

// File: rtl/mult_slice_pipe_cfg_cfg_chain.sv
// Serial configuration chain of the slice: a shift register loaded from ccff_head.
// Exposes the decoded mode word and the chain's serial output.
module mult_slice_cfg_chain
    import mult_slice_pkg::*;
#(
    parameter int CFG_W = 6
) (
    input  logic  clk,
    input  logic  pReset_n,
    input  logic  config_enable,
    input  logic  ccff_head,
    output logic  ccff_tail,
    output mode_t mode
);

    logic [CFG_W-1:0] cfg_reg;

    always_ff @(posedge clk or negedge pReset_n) begin
        if (!pReset_n) begin
            cfg_reg <= '0;
        end else if (config_enable) begin
            cfg_reg <= {cfg_reg[CFG_W-2:0], ccff_head};
        end
    end

    assign ccff_tail = cfg_reg[CFG_W-1];
    assign mode      = decode_mode(cfg_reg);

endmodule

// File: rtl/mult_slice_pipe_cfg.sv
// Configurable multiplier slice: signed/unsigned, fracturable dual half-width mode,
// 0-2 pipeline stages with valid tracking and an optional wrapping accumulator.
module mult_slice_pipe_cfg
    import mult_slice_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int CFG_W = mult_slice_pkg::CFG_W
) (
    input  logic clk,
    input  logic pReset_n,
    input  logic config_enable,
    input  logic ccff_head,
    output logic ccff_tail,
    mult_slice_pipe_cfg_if.slave bus
);

    localparam int P_W = A_W + B_W;
    localparam int HA  = A_W / 2;
    localparam int HB  = B_W / 2;
    localparam int H_W = HA + HB;

    mode_t      mode;
    logic [1:0] lat_eff;
    logic       acc_active;

    mult_slice_cfg_chain #(
        .CFG_W(CFG_W)
    ) u_cfg_chain (
        .clk          (clk),
        .pReset_n     (pReset_n),
        .config_enable(config_enable),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .mode         (mode)
    );

    assign lat_eff    = clamp_lat(mode.lat);
    assign acc_active = mode.acc_en & ~mode.frac;

    // Full-width product: only the low P_W bits are kept, so extending both
    // operands to P_W and multiplying modulo 2^P_W gives the exact result.
    logic [P_W-1:0] a_full;
    logic [P_W-1:0] b_full;
    logic [P_W-1:0] prod_norm;

    assign a_full    = {{B_W{mode.sign_a & bus.mult_A[A_W-1]}}, bus.mult_A};
    assign b_full    = {{A_W{mode.sign_b & bus.mult_B[B_W-1]}}, bus.mult_B};
    assign prod_norm = a_full * b_full;

    // Fracturable halves: each half multiplies in its own H_W-bit field, so no
    // carry can leak from the low product into the high one.
    logic [H_W-1:0] half_prod [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        logic [HA-1:0]  a_h;
        logic [HB-1:0]  b_h;
        logic [H_W-1:0] a_x;
        logic [H_W-1:0] b_x;

        assign a_h = bus.mult_A[gi*HA +: HA];
        assign b_h = bus.mult_B[gi*HB +: HB];
        assign a_x = {{HB{mode.sign_a & a_h[HA-1]}}, a_h};
        assign b_x = {{HA{mode.sign_b & b_h[HB-1]}}, b_h};
        assign half_prod[gi] = a_x * b_x;
    end

    logic [P_W-1:0] prod_comb;

    assign prod_comb = mode.frac ? {half_prod[1], half_prod[0]} : prod_norm;

    // Pipeline stages; config_enable flushes every valid bit so in-flight
    // operands are discarded and new operands are dropped.
    logic           valid_s1_reg;
    logic           valid_s2_reg;
    logic [P_W-1:0] prod_s1_reg;
    logic [P_W-1:0] prod_s2_reg;

    always_ff @(posedge clk or negedge pReset_n) begin
        if (!pReset_n) begin
            valid_s1_reg <= 1'b0;
            valid_s2_reg <= 1'b0;
            prod_s1_reg  <= '0;
            prod_s2_reg  <= '0;
        end else if (config_enable) begin
            valid_s1_reg <= 1'b0;
            valid_s2_reg <= 1'b0;
        end else begin
            valid_s1_reg <= bus.in_valid;
            valid_s2_reg <= valid_s1_reg;
            if (bus.in_valid) begin
                prod_s1_reg <= prod_comb;
            end
            if (valid_s1_reg) begin
                prod_s2_reg <= prod_s1_reg;
            end
        end
    end

    logic           sel_valid;
    logic [P_W-1:0] sel_prod;

    always_comb begin
        sel_valid = bus.in_valid;
        sel_prod  = prod_comb;
        case (lat_eff)
            2'd1: begin
                sel_valid = valid_s1_reg;
                sel_prod  = prod_s1_reg;
            end
            2'd2: begin
                sel_valid = valid_s2_reg;
                sel_prod  = prod_s2_reg;
            end
            default: begin
            end
        endcase
    end

    // The zero-latency path is combinational, so reset must mask it directly.
    logic out_valid_int;

    assign out_valid_int = sel_valid & ~config_enable & pReset_n;

    logic [P_W-1:0] acc_reg;
    logic [P_W-1:0] acc_next;
    logic [P_W-1:0] acc_sum;
    logic [P_W-1:0] result;
    logic [P_W-1:0] y_hold_reg;

    // acc_clr together with a result means "clear, then add this product".
    assign acc_sum = (bus.acc_clr ? '0 : acc_reg) + sel_prod;
    assign result  = acc_active ? acc_sum : sel_prod;

    always_comb begin
        acc_next = acc_reg;
        if (config_enable || !acc_active) begin
            acc_next = '0;
        end else if (out_valid_int) begin
            acc_next = acc_sum;
        end else if (bus.acc_clr) begin
            acc_next = '0;
        end
    end

    always_ff @(posedge clk or negedge pReset_n) begin
        if (!pReset_n) begin
            acc_reg    <= '0;
            y_hold_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            if (out_valid_int) begin
                y_hold_reg <= result;
            end
        end
    end

    assign bus.out_valid = out_valid_int;
    assign bus.mult_Y    = out_valid_int ? result : y_hold_reg;

endmodule

// File: doc/mult_slice_pipe_cfg.md
Name: mult_slice_pipe_cfg

Overview:
- Parametrised successor to the fixed 18x18 multiplier slice in the mult_18 logical tile.
- Adds a runtime-configurable signed/unsigned mode and a fracturable dual half-width mode.
- Adds 0–2 programmable pipeline stages, valid tracking, and an optional accumulator.
- Mode bits load through the tile's configuration chain (ccff_head to ccff_tail); datapath and chain share one clock.

Parameters:
- A_W, 18, operand A width; must be even and >= 4.
- B_W, 18, operand B width; must be even and >= 4.
- CFG_W, 6, configuration chain length (fixed layout, below).

Ports:
- clk  in  1  single clock for config chain and datapath.
- pReset_n  in  1  asynchronous active-low reset.
- config_enable  in  1  1 = chain shifts, datapath held in flush.
- ccff_head  in  1  config chain serial in.
- ccff_tail  out  1  config chain serial out; equals cfg[CFG_W-1].
- in_valid  in  1  operands valid this cycle.
- mult_A  in  A_W  operand A.
- mult_B  in  B_W  operand B.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  mult_Y valid.
- mult_Y  out  A_W+B_W  product / accumulated result.

Behaviour:
- Reset (pReset_n=0, async): cfg=0, all pipeline data/valid regs=0, accumulator=0, out_valid=0, mult_Y=0, ccff_tail=0.
- Config chain: each clk with config_enable=1, cfg[0]<=ccff_head and cfg[i]<=cfg[i-1]. First bit shifted in ends at cfg[CFG_W-1] after CFG_W cycles.
- Config bit map:
  - cfg[0] sign_a, cfg[1] sign_b: 1 = operand two's-complement.
  - cfg[2] frac.
  - cfg[4:3] lat: 0, 1, 2; value 3 behaves as 2.
  - cfg[5] acc_en.
- While config_enable=1: all stage valids cleared, accumulator cleared, out_valid=0, mult_Y holds its value.
- Data loss: operands presented with config_enable=1 are dropped. Operands in flight when config_enable rises are discarded.
- Normal mode (frac=0): mult_Y = ext(A)*ext(B), full A_W+B_W bits. ext sign- or zero-extends per sign_a/sign_b; mixed signedness is allowed.
- Frac mode (frac=1), with HA=A_W/2 and HB=B_W/2:
  - Low product: A[HA-1:0]*B[HB-1:0] into mult_Y[HA+HB-1:0].
  - High product: A[A_W-1:HA]*B[B_W-1:HB] into mult_Y[A_W+B_W-1:HA+HB].
  - Each half uses its own top bit for signedness. Halves are independent, with no carry between them.
- Latency L = lat (clamped):
  - out_valid = in_valid delayed L cycles.
  - L=0: mult_Y/out_valid are combinational from inputs (plus accumulator).
  - L>=1: registered; fully pipelined, one result per cycle, no back-pressure.
- mult_Y holds its last value while out_valid=0; it updates only on a valid result.
- Accumulator (active only if acc_en=1 and frac=0):
  - On out_valid, acc <= acc + product and mult_Y = new acc. Wraps modulo 2^(A_W+B_W).
  - acc_clr without out_valid: acc <= 0.
  - acc_clr with out_valid in the same cycle: acc <= product (clear then add).
  - acc_en=0 or frac=1: acc_clr is ignored and the accumulator stays 0.
- Config changes take effect only through the chain; with config_enable=0, cfg is stable.

Decomposition:
- Shared package mult_slice_pkg:
  - CFG bit-index constants (CFG_SIGN_A=0, CFG_SIGN_B=1, CFG_FRAC=2, CFG_LAT_LO=3, CFG_LAT_HI=4, CFG_ACC=5), CFG_W=6.
  - Typedef for the decoded mode struct {sign_a, sign_b, frac, lat[1:0], acc_en}.
- One sub-module, mult_slice_cfg_chain: CFG_W-bit shift register with async active-low reset. Outputs the decoded mode struct and ccff_tail.
- The multiplier/pipeline/accumulator stay in the top.

Test Plan:
1. Reset then shift 6'b000000, lat=0. A=3, B=5, in_valid=1 -> same-cycle out_valid=1, mult_Y=15.
2. Chain: shift 6 bits, first bit=1, rest 0 -> cfg[5]=1 (acc_en), ccff_tail=1 during the 6th post-shift cycle. Mid-shift async reset -> ccff_tail=0 immediately, cfg=0.
3. sign_a=sign_b=1, lat=2. A=-1 (18'h3FFFF), B=2 -> out_valid exactly 2 cycles after in_valid, mult_Y=36'hFFFFFFFFE. Back-to-back inputs give back-to-back outputs.
4. frac=1, unsigned, lat=1. A={9'd7,9'd3}, B={9'd2,9'd4} -> mult_Y={18'd14,18'd12} one cycle later.
5. acc_en=1, lat=1. Products 10, 20, 30 on consecutive cycles -> mult_Y 10, 30, 60. acc_clr with the 4th product 5 -> mult_Y=5.
6. lat=2, two operands in flight, raise config_enable -> out_valid never asserts for them, accumulator=0, mult_Y unchanged.
